tuner_step_scheduler: RTL

Sequences the tuner stepper-driver step/dir outputs from two requesters: the manual command path (start / start_N / stop, period, pulse count, direction from the register bank) and the automatic tuning loops (TR_AUTO / TX / TP step requests). It enforces pulse width, minimum period and direction-setup time, counts issued steps and reports completion. It sits between the Avalon-MM parameter block and the physical step/dir pins.

---
 rtl/tuner_step_scheduler.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/tuner_step_scheduler.sv
// Tuner stepper step/dir sequencer. Arbitrates between the manual command
// path and the automatic tuning loops, and enforces pulse width, minimum
// period and direction-setup time on the driver pins.
module tuner_step_scheduler #(
    parameter int PULSE_WIDTH = 4,
    parameter int DIR_SETUP   = 8,
    parameter int MIN_PERIOD  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        auto_i,
    input  logic        turn_on_rf_i,
    input  logic        start_i,
    input  logic        start_N_i,
    input  logic        stop_i,
    input  logic [31:0] period_manual_i,
    input  logic [31:0] pulse_number_i,
    input  logic        dir_manual_i,
    input  logic        count_en_i,
    input  logic        auto_step_req_i,
    input  logic        auto_dir_i,
    input  logic [31:0] auto_period_i,
    output logic        step_o,
    output logic        dir_o,
    output logic        busy_o,
    output logic        auto_step_ack_o,
    output logic        done_o,
    output logic [31:0] pulse_count_o
);

    localparam logic [31:0] PW   = 32'(PULSE_WIDTH);
    localparam logic [31:0] DS   = 32'(DIR_SETUP);
    localparam logic [31:0] MINP = 32'(MIN_PERIOD);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;
    typedef enum logic [1:0] {M_CONT, M_N, M_AUTO} mode_t;

    state_t      state_q;
    mode_t       mode_q;
    logic [31:0] cnt_q, period_q, rem_q, pc_q;
    logic        stop_seen_q, step_q, dir_q, busy_q, ack_q, done_q;

    logic [31:0] man_p, auto_p, hi_p, rem_base;
    logic        low_end, setup_end, stop_now, abort_setup;
    logic        launch, l_dir, clr_pc, zero_n, dir_chg, enter_high;
    mode_t       l_mode, hi_mode;

    assign man_p       = (period_manual_i < MINP) ? MINP : period_manual_i;
    assign auto_p      = (auto_period_i < MINP) ? MINP : auto_period_i;
    assign low_end     = (state_q == S_LOW) && (cnt_q == period_q - PW - 32'd1);
    assign setup_end   = (state_q == S_SETUP) && (cnt_q == DS - 32'd1);
    // Manual stop only counts while the manual requester owns the driver.
    assign stop_now    = stop_i && !auto_i;
    assign abort_setup = (state_q == S_SETUP) && (mode_q != M_AUTO) && (stop_seen_q || stop_now);

    // Launch decision: new run from IDLE, or follow-on step at the end of LOW.
    always_comb begin
        launch = 1'b0;
        l_mode = mode_q;
        l_dir  = dir_q;
        clr_pc = 1'b0;
        zero_n = 1'b0;
        if (state_q == S_IDLE) begin
            if (!auto_i) begin
                if (!stop_i && start_N_i) begin
                    clr_pc = 1'b1;
                    if (pulse_number_i == 32'd0) begin
                        zero_n = 1'b1;
                    end else begin
                        launch = 1'b1;
                        l_mode = M_N;
                        l_dir  = dir_manual_i;
                    end
                end else if (!stop_i && start_i) begin
                    clr_pc = 1'b1;
                    launch = 1'b1;
                    l_mode = M_CONT;
                    l_dir  = dir_manual_i;
                end
            end else if (turn_on_rf_i && auto_step_req_i) begin
                launch = 1'b1;
                l_mode = M_AUTO;
                l_dir  = auto_dir_i;
            end
        end else if (low_end) begin
            case (mode_q)
                M_CONT: begin
                    launch = !auto_i && !stop_seen_q && !stop_now;
                    l_dir  = dir_manual_i;
                end
                M_N: begin
                    launch = !auto_i && !stop_seen_q && !stop_now && (rem_q != 32'd0);
                    l_dir  = dir_manual_i;
                end
                default: begin
                    launch = auto_i && turn_on_rf_i && auto_step_req_i;
                    l_dir  = auto_dir_i;
                end
            endcase
        end
    end

    assign dir_chg    = launch && (l_dir != dir_q);
    assign enter_high = (launch && !dir_chg) || (setup_end && !abort_setup);
    assign hi_mode    = launch ? l_mode : mode_q;
    assign hi_p       = (hi_mode == M_AUTO) ? auto_p : man_p;
    assign rem_base   = (state_q == S_IDLE) ? pulse_number_i : rem_q;

    // Step FSM with all driver-facing outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= M_CONT;
            cnt_q       <= '0;
            period_q    <= '0;
            rem_q       <= '0;
            pc_q        <= '0;
            stop_seen_q <= 1'b0;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;
            if (clr_pc)
                pc_q <= (enter_high && count_en_i) ? 32'd1 : 32'd0;
            else if (enter_high && count_en_i)
                pc_q <= pc_q + 32'd1;
            if (state_q != S_IDLE && stop_now)
                stop_seen_q <= 1'b1;
            if (launch) begin
                mode_q <= l_mode;
                dir_q  <= l_dir;
                busy_q <= 1'b1;
                if (state_q == S_IDLE) begin
                    stop_seen_q <= 1'b0;
                    rem_q       <= pulse_number_i;
                end
            end
            if (enter_high) begin
                state_q  <= S_HIGH;
                step_q   <= 1'b1;
                cnt_q    <= '0;
                period_q <= hi_p;
                ack_q    <= (hi_mode == M_AUTO);
                if (hi_mode == M_N)
                    rem_q <= rem_base - 32'd1;
            end else if (dir_chg) begin
                state_q <= S_SETUP;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: if (zero_n) done_q <= 1'b1;
                    S_SETUP: begin
                        if (abort_setup) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    S_HIGH: begin
                        if (cnt_q == PW - 32'd1) begin
                            state_q <= S_LOW;
                            step_q  <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    default: begin
                        if (low_end) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign step_o          = step_q;
    assign dir_o           = dir_q;
    assign busy_o          = busy_q;
    assign auto_step_ack_o = ack_q;
    assign done_o          = done_q;
    assign pulse_count_o   = pc_q;

endmodule
